// File: rtl/simon_data_in_if.sv
// rtl/simon_data_in_if.sv - host byte link and core packet handshake bundle for simon_data_in
interface simon_data_in_if #(
    parameter int N = 16
);
    // Host byte link
    logic [7:0]         byteIN;
    logic               validIN;
    logic               readBYTE;

    // Core-side packet handshake
    logic [7:0]         infoIN;
    logic [7:0]         countIN;
    logic [1:0][N-1:0]  inDATA;
    logic               doneDATA;
    logic               readDATA;

    // Status
    logic               errSEQ;

    // The receiver itself
    modport slave (
        input  byteIN,
        input  validIN,
        input  readDATA,
        output readBYTE,
        output infoIN,
        output countIN,
        output inDATA,
        output doneDATA,
        output errSEQ
    );

    // Host plus core environment around the receiver
    modport master (
        output byteIN,
        output validIN,
        output readDATA,
        input  readBYTE,
        input  infoIN,
        input  countIN,
        input  inDATA,
        input  doneDATA,
        input  errSEQ
    );
endinterface

// File: rtl/simon_data_in.sv
// rtl/simon_data_in.sv - byte-serial packet receiver for the SIMON core (optional SIMON_SEQ_CHECK_EN count check)
module simon_data_in #(
    parameter int N = 16        // SIMON word size, multiple of 8
) (
    input  logic            clk,
    input  logic            nR,
    simon_data_in_if.slave  bus
);

    // Payload is two N-bit words, i.e. N/4 bytes
    localparam int P  = N / 4;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(P - 1);

    typedef enum logic [1:0] {
        INFO    = 2'd0,
        COUNT   = 2'd1,
        PAYLOAD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t             state;
    state_t             stateNext;

    logic [CW-1:0]      byteCnt;
    logic [7:0]         infoReg;
    logic [7:0]         countReg;
    logic [2*N-1:0]     dataReg;
    logic               readByteReg;
    logic               doneReg;

    logic               accept;
    logic               loadInfo;
    logic               loadCount;
    logic               loadData;
    logic               readByteNext;
    logic               doneNext;

    // A byte moves only when the host offers it and we advertised readiness
    assign accept = bus.validIN && readByteReg;

    // State register
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state <= INFO;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and per-field load strobes
    always_comb begin
        stateNext = state;
        loadInfo  = 1'b0;
        loadCount = 1'b0;
        loadData  = 1'b0;
        case (state)
            INFO: begin
                if (accept) begin
                    loadInfo  = 1'b1;
                    stateNext = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    loadCount = 1'b1;
                    stateNext = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    loadData = 1'b1;
                    if (byteCnt == LAST_BYTE) begin
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                // readDATA only matters here; elsewhere it is ignored
                if (bus.readDATA) begin
                    stateNext = INFO;
                end
            end
            default: begin
                stateNext = INFO;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so that the
    // edge entering HOLD drops readBYTE and raises doneDATA together
    assign readByteNext = (stateNext != HOLD);
    assign doneNext     = (stateNext == HOLD);

    // Registered handshake flags; readBYTE comes up on the first edge after reset
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            readByteReg <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            readByteReg <= readByteNext;
            doneReg     <= doneNext;
        end
    end

    // Payload byte index, restarted by every count byte
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            byteCnt <= '0;
        end else if (loadCount) begin
            byteCnt <= '0;
        end else if (loadData) begin
            byteCnt <= byteCnt + CW'(1);
        end
    end

    // Header fields, written in place as they arrive
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            infoReg  <= 8'h00;
            countReg <= 8'h00;
        end else begin
            if (loadInfo) begin
                infoReg <= bus.byteIN;
            end
            if (loadCount) begin
                countReg <= bus.byteIN;
            end
        end
    end

    // Payload bytes land LSB first; lanes 0..N/8-1 form word 0, the rest word 1
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            dataReg <= '0;
        end else if (loadData) begin
            for (int k = 0; k < P; k++) begin
                if (byteCnt == CW'(k)) begin
                    dataReg[k*8 +: 8] <= bus.byteIN;
                end
            end
        end
    end

`ifdef SIMON_SEQ_CHECK_EN
    logic [7:0] expCount;
    logic       errReg;

    // Expected count always follows the last received count so a single
    // glitch flags once and the check resyncs on the next packet
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            expCount <= 8'h00;
            errReg   <= 1'b0;
        end else if (loadCount) begin
            expCount <= bus.byteIN + 8'h01;
            if (bus.byteIN != expCount) begin
                errReg <= 1'b1;
            end
        end
    end

    assign bus.errSEQ = errReg;
`else
    assign bus.errSEQ = 1'b0;
`endif

    assign bus.readBYTE = readByteReg;
    assign bus.doneDATA = doneReg;
    assign bus.infoIN   = infoReg;
    assign bus.countIN  = countReg;
    assign bus.inDATA   = dataReg;

endmodule

// File: tb/tb_simon_data_in.sv
// tb/tb_simon_data_in.sv - directed self-checking bench for simon_data_in
module tb_simon_data_in;

    localparam int N = 16;

`ifdef SIMON_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic clk;
    logic nR;
    int   total;
    int   bad;
    int   doneRises;
    logic donePrev;

    simon_data_in_if #(.N(N)) bus ();

    simon_data_in #(.N(N)) dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising doneDATA so each packet can be shown to complete once
    initial begin
        doneRises = 0;
        donePrev  = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.doneDATA && !donePrev) doneRises++;
        donePrev = bus.doneDATA;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after an optional idle gap and wait for it to be taken
    task automatic sendByte(input logic [7:0] b, input int gap);
        int budget;
        budget = 0;
        for (int i = 0; i < gap; i++) begin
            bus.validIN = 1'b0;
            tick();
        end
        bus.byteIN  = b;
        bus.validIN = 1'b1;
        while (!bus.readBYTE && budget < 100) begin
            tick();
            budget++;
        end
        if (!bus.readBYTE) check("byte_accept_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic sendPacket(input logic [7:0] info, input logic [7:0] cnt,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int gap);
        sendByte(info, gap);
        sendByte(cnt, gap);
        sendByte(b0, gap);
        sendByte(b1, gap);
        sendByte(b2, gap);
        sendByte(b3, gap);
        bus.validIN = 1'b0;
    endtask

    task automatic checkPacket(input string tag, input logic [7:0] info, input logic [7:0] cnt,
                               input logic [15:0] w0, input logic [15:0] w1);
        check({tag, "_done"},  32'(bus.doneDATA),  32'd1);
        check({tag, "_rdbyte"}, 32'(bus.readBYTE), 32'd0);
        check({tag, "_info"},  32'(bus.infoIN),    32'(info));
        check({tag, "_count"}, 32'(bus.countIN),   32'(cnt));
        check({tag, "_w0"},    32'(bus.inDATA[0]), 32'(w0));
        check({tag, "_w1"},    32'(bus.inDATA[1]), 32'(w1));
    endtask

    task automatic pulseRead(input string tag);
        bus.readDATA = 1'b1;
        tick();
        bus.readDATA = 1'b0;
        check({tag, "_done_clr"}, 32'(bus.doneDATA), 32'd0);
        check({tag, "_rdbyte_up"}, 32'(bus.readBYTE), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rdbyte"}, 32'(bus.readBYTE), 32'd0);
        check({tag, "_done"},   32'(bus.doneDATA), 32'd0);
        check({tag, "_info"},   32'(bus.infoIN),   32'd0);
        check({tag, "_count"},  32'(bus.countIN),  32'd0);
        check({tag, "_data"},   32'(bus.inDATA),   32'd0);
        check({tag, "_err"},    32'(bus.errSEQ),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int riseBase;
        total = 0;
        bad   = 0;
        nR           = 1'b1;
        bus.byteIN   = 8'h00;
        bus.validIN  = 1'b0;
        bus.readDATA = 1'b0;

        // Reset and release
        #2 nR = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        nR = 1'b1;
        check("rel_rdbyte_before_edge", 32'(bus.readBYTE), 32'd0);
        tick();
        check("rel_rdbyte_after_edge", 32'(bus.readBYTE), 32'd1);
        check("rel_done", 32'(bus.doneDATA), 32'd0);

        // Single continuous packet
        sendPacket(8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 0);
        checkPacket("pkt1", 8'hA5, 8'h00, 16'h2211, 16'h4433);
        pulseRead("pkt1");

        // Backpressure while holding a packet
        sendPacket(8'hA5, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88, 0);
        checkPacket("pkt2", 8'hA5, 8'h01, 16'h6655, 16'h8877);
        bus.byteIN  = 8'h77;
        bus.validIN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rdbyte_low", 32'(bus.readBYTE), 32'd0);
        end
        checkPacket("bp_hold", 8'hA5, 8'h01, 16'h6655, 16'h8877);
        pulseRead("bp");
        tick();
        check("bp_77_info", 32'(bus.infoIN), 32'h77);
        sendByte(8'h02, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h33, 0);
        sendByte(8'h44, 0);
        bus.validIN = 1'b0;
        checkPacket("pkt3", 8'h77, 8'h02, 16'h2211, 16'h4433);
        pulseRead("pkt3");

        // Gapped input, doneDATA must rise exactly once
        riseBase = doneRises;
        sendPacket(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 3);
        checkPacket("gap", 8'hA5, 8'h03, 16'h2211, 16'h4433);
        tick();
        tick();
        check("gap_still_done", 32'(bus.doneDATA), 32'd1);
        pulseRead("gap");
        tick();
        check("gap_done_once", 32'(doneRises - riseBase), 32'd1);

        // readDATA held high across HOLD entry is taken on the first HOLD edge
        bus.readDATA = 1'b1;
        sendPacket(8'hB0, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 0);
        checkPacket("rdhold", 8'hB0, 8'h04, 16'h0201, 16'h0403);
        tick();
        bus.readDATA = 1'b0;
        check("rdhold_done_clr", 32'(bus.doneDATA), 32'd0);
        check("rdhold_rdbyte", 32'(bus.readBYTE), 32'd1);

        // Reset in the middle of the payload
        sendByte(8'h5A, 0);
        sendByte(8'h05, 0);
        sendByte(8'hEE, 0);
        sendByte(8'hFF, 0);
        bus.validIN = 1'b0;
        nR = 1'b0;
        #1;
        checkAllZero("midrst");
        tick();
        nR = 1'b1;
        tick();
        check("midrst_rdbyte", 32'(bus.readBYTE), 32'd1);
        sendPacket(8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
        checkPacket("after_rst", 8'h01, 8'h00, 16'hBBAA, 16'hDDCC);
        check("after_rst_err", 32'(bus.errSEQ), 32'd0);
        pulseRead("after_rst");

        // Sequence check: 00 done above, then 01, 03, 04
        sendPacket(8'hC1, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 0);
        checkPacket("seq01", 8'hC1, 8'h01, 16'h2010, 16'h4030);
        check("seq01_err", 32'(bus.errSEQ), 32'd0);
        pulseRead("seq01");
        sendByte(8'hC3, 0);
        sendByte(8'h03, 0);
        check("seq03_err_edge", 32'(bus.errSEQ), 32'(SEQ_ON));
        sendByte(8'h1A, 0);
        sendByte(8'h2B, 0);
        sendByte(8'h3C, 0);
        sendByte(8'h4D, 0);
        bus.validIN = 1'b0;
        checkPacket("seq03", 8'hC3, 8'h03, 16'h2B1A, 16'h4D3C);
        pulseRead("seq03");
        check("seq03_err_sticky", 32'(bus.errSEQ), 32'(SEQ_ON));
        sendPacket(8'hC4, 8'h04, 8'h01, 8'h23, 8'h45, 8'h67, 0);
        checkPacket("seq04", 8'hC4, 8'h04, 16'h2301, 16'h6745);
        check("seq04_err", 32'(bus.errSEQ), 32'(SEQ_ON));
        pulseRead("seq04");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
